// File: rtl/ram_ins_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_ins_fetch_if : RAM read port plus decode-stage valid/ready handshake |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface ram_ins_fetch_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] RamAddr;
    logic              RamRd;
    logic [DATA_W-1:0] RamQ;
    logic [DATA_W-1:0] Ins;
    logic              InsValid;
    logic              InsReady;
    logic              JumpEn;
    logic [ADDR_W-1:0] JumpAddr;

    modport master (
        output RamAddr, RamRd, Ins, InsValid,
        input  RamQ, InsReady, JumpEn, JumpAddr
    );

    modport slave (
        input  RamAddr, RamRd, Ins, InsValid,
        output RamQ, InsReady, JumpEn, JumpAddr
    );
endinterface
`default_nettype wire

// File: rtl/ram_ins_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_ins_fetch : reads the loaded program from instruction RAM and hands  |
// | it to decode one instruction at a time, with jumps and halt detection.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ram_ins_fetch #(
    parameter int                ADDR_W      = 5,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  wire logic              Clock,
    input  wire logic              Reset,
    input  wire logic              LoadActive,
    input  wire logic              Start,
    ram_ins_fetch_if.master        bus,
    output logic      [ADDR_W-1:0] PC,
    output logic                   Busy,
    output logic                   Halted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] C_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] ins_q,   ins_d;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
        end
    end

    // A loader request in any busy state aborts; PC and Ins stay untouched.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (Start && !LoadActive) begin
                    pc_d    = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = LoadActive ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (LoadActive) begin
                    state_d = S_IDLE;
                end else if (bus.RamQ == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else begin
                    ins_d   = bus.RamQ;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (LoadActive) begin
                    state_d = S_IDLE;
                end else if (bus.InsReady) begin
                    pc_d    = bus.JumpEn ? bus.JumpAddr : pc_q + C_PC_ONE;
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All handshake and status outputs are Moore decodes of the state register.
    assign bus.RamAddr  = pc_q;
    assign bus.RamRd    = (state_q == S_ISSUE);
    assign bus.Ins      = ins_q;
    assign bus.InsValid = (state_q == S_HOLD);
    assign PC           = pc_q;
    assign Busy         = (state_q != S_IDLE) && (state_q != S_HALT);
    assign Halted       = (state_q == S_HALT);

endmodule
`default_nettype wire
